// File: rtl/bus_master_port.sv
// Requester-side agent for the arbitrated bus: takes one local command, requests the bus,
// runs a single address/data transfer while granted, releases the bus and reports status.
module bus_master_port #(
  parameter int AddrWidth     = 16,
  parameter int DataWidth     = 16,
  parameter int GrantTimeout  = 255,
  parameter int TargetTimeout = 255
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 BARQ,
  input  logic                 BAGD,
  output logic                 AddressValid,
  output logic                 DataStrobe,
  input  logic                 TargetReady,
  output logic [AddrWidth-1:0] bus_addr,
  output logic                 bus_we,
  output logic [DataWidth-1:0] bus_wdata,
  input  logic [DataWidth-1:0] bus_rdata,
  output logic                 rsp_valid,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic [7:0]           Error,
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int MaxTimeout = (GrantTimeout > TargetTimeout) ? GrantTimeout : TargetTimeout;
  localparam int CntWidth   = $clog2(MaxTimeout + 1);
  localparam logic [CntWidth-1:0] GrantLast  = CntWidth'(GrantTimeout - 1);
  localparam logic [CntWidth-1:0] TargetLast = CntWidth'(TargetTimeout - 1);

  state_t                 state;
  logic [CntWidth-1:0]    cnt;
  logic [AddrWidth-1:0]   lat_addr;
  logic                   lat_we;
  logic [DataWidth-1:0]   lat_wdata;
  logic                   to_done;
  logic [7:0]             done_code;
  logic                   capture;

  assign fsm_state = state;

  // Every exit towards DONE, with the status it leaves behind. Grant loss is tested first
  // so it beats both TargetReady and the timeout in the same cycle.
  always_comb begin
    to_done   = 1'b0;
    done_code = 8'h00;
    capture   = 1'b0;
    case (state)
      REQ: begin
        if (!BAGD && cnt == GrantLast) begin
          to_done   = 1'b1;
          done_code = 8'h01;
        end
      end
      ADDR: begin
        if (!BAGD) begin
          to_done   = 1'b1;
          done_code = 8'h03;
        end
      end
      DATA: begin
        if (!BAGD) begin
          to_done   = 1'b1;
          done_code = 8'h03;
        end else if (TargetReady) begin
          to_done = 1'b1;
          capture = !lat_we;
        end else if (cnt == TargetLast) begin
          to_done   = 1'b1;
          done_code = 8'h02;
        end
      end
      default: ;
    endcase
  end

  // Command handshake: a command transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and does not depend on req_valid.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready    <= 1'b1;
      BARQ         <= 1'b0;
      AddressValid <= 1'b0;
      DataStrobe   <= 1'b0;
      bus_addr     <= '0;
      bus_we       <= 1'b0;
      bus_wdata    <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      Error        <= 8'h00;
      lat_addr     <= '0;
      lat_we       <= 1'b0;
      lat_wdata    <= '0;
    end else if (to_done) begin
      state        <= DONE;
      cnt          <= '0;
      BARQ         <= 1'b0;
      AddressValid <= 1'b0;
      DataStrobe   <= 1'b0;
      bus_addr     <= '0;
      bus_we       <= 1'b0;
      bus_wdata    <= '0;
      rsp_valid    <= 1'b1;
      Error        <= done_code;
      if (capture) rsp_rdata <= bus_rdata;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= REQ;
            cnt       <= '0;
            req_ready <= 1'b0;
            BARQ      <= 1'b1;
            lat_addr  <= req_addr;
            lat_we    <= req_write;
            lat_wdata <= req_wdata;
            Error     <= 8'h00;
          end
        end
        REQ: begin
          if (BAGD) begin
            state        <= ADDR;
            cnt          <= '0;
            AddressValid <= 1'b1;
            bus_addr     <= lat_addr;
            bus_we       <= lat_we;
            bus_wdata    <= lat_wdata;
          end else begin
            cnt <= cnt + CntWidth'(1);
          end
        end
        ADDR: begin
          state      <= DATA;
          cnt        <= '0;
          DataStrobe <= 1'b1;
        end
        DATA: cnt <= cnt + CntWidth'(1);
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed vector table, reset and back-to-back sequences, and
// randomized transactions checked against a transaction-level model of the bus rules.
module tb_bus_master_port;

  localparam int GT = 8;
  localparam int TT = 6;

  logic        clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        BARQ;
  logic        BAGD;
  logic        AddressValid;
  logic        DataStrobe;
  logic        TargetReady;
  logic [15:0] bus_addr;
  logic        bus_we;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [7:0]  Error;
  logic [2:0]  fsm_state;

  bus_master_port #(
    .AddrWidth(16), .DataWidth(16), .GrantTimeout(GT), .TargetTimeout(TT)
  ) dut (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .BARQ(BARQ), .BAGD(BAGD), .AddressValid(AddressValid), .DataStrobe(DataStrobe),
    .TargetReady(TargetReady), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .Error(Error),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_rdata;

  // g: REQ cycles with BAGD low before grant (>= GT never grants)
  // w: DATA wait cycles before TargetReady (>= TT times out)
  // drop: ownership cycle (1 = ADDR, 2 = first DATA, ...) with BAGD low; 0 = never
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          g;
    int          w;
    int          drop;
    logic [7:0]  e_err;
    logic [15:0] e_rdata;
    int          e_lat;
    int          e_barq;
    int          e_av;
    int          e_ds;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: cycle counts per phase from the bus rules.
  function automatic vec_t model(input vec_t v, input logic [15:0] prev);
    vec_t r;
    int req_c, own_c, d, nat;
    r = v;
    r.e_rdata = prev;
    r.e_err = 8'h00;
    if (v.g >= GT) begin
      req_c = GT; own_c = 0; d = 0; r.e_err = 8'h01;
    end else begin
      req_c = v.g + 1;
      if (v.drop == 1) begin
        d = 0; r.e_err = 8'h03;
      end else begin
        nat = (v.w < TT) ? v.w + 1 : TT;
        if (v.drop >= 2 && v.drop - 1 <= nat) begin
          d = v.drop - 1; r.e_err = 8'h03;
        end else begin
          d = nat;
          if (v.w >= TT) r.e_err = 8'h02;
          else if (!v.wr) r.e_rdata = v.rdata;
        end
      end
      own_c = 1 + d;
    end
    r.e_lat  = req_c + own_c + 1;
    r.e_barq = req_c + own_c;
    r.e_av   = own_c;
    r.e_ds   = d;
    return r;
  endfunction

  // ---------------- driver ----------------
  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_txn(input vec_t v);
    int cyc, barq_n, av_n, ds_n, req_n, own_n, dd;
    bit done, bus_ok;
    logic [15:0] exp_rd;
    cyc = 0; barq_n = 0; av_n = 0; ds_n = 0; req_n = 0; own_n = 0; dd = 0;
    done = 1'b0; bus_ok = 1'b1;
    exp_q.push_back(v.e_rdata);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    bus_rdata = v.rdata; BAGD = (v.g == 0); TargetReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~v.wr; req_addr = 16'($urandom); req_wdata = 16'($urandom);
    while (!done && cyc < 80) begin
      cyc++;
      if (rsp_valid) begin
        done = 1'b1;
        exp_rd = exp_q.pop_front();
        check("err", Error, v.e_err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("latency", cyc, v.e_lat);
        check("barq_cycles", barq_n, v.e_barq);
        check("av_cycles", av_n, v.e_av);
        check("ds_cycles", ds_n, v.e_ds);
        check("bus_values", bus_ok, 1);
        check("done_bus_idle", {BARQ, AddressValid, DataStrobe, bus_we, bus_addr, bus_wdata}, 0);
        BAGD = 1'b0; TargetReady = 1'b0;
      end else begin
        if (BARQ) barq_n++;
        if (AddressValid) av_n++;
        if (DataStrobe) ds_n++;
        if (AddressValid)
          bus_ok &= (bus_addr == v.addr) && (bus_we == v.wr) && (bus_wdata == v.wdata);
        else
          bus_ok &= (bus_addr == 16'h0) && !bus_we && (bus_wdata == 16'h0) && !DataStrobe;
        if (BARQ && !AddressValid) begin
          BAGD = (req_n >= v.g);
          req_n++;
          TargetReady = 1'($urandom_range(0, 1));
        end else if (AddressValid) begin
          own_n++;
          BAGD = (own_n != v.drop);
          if (DataStrobe) begin
            TargetReady = (dd >= v.w);
            dd++;
          end else begin
            TargetReady = 1'($urandom_range(0, 1));
          end
        end
        @(negedge clk);
      end
    end
    if (!done) begin
      check("rsp_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check("post_idle", {rsp_valid, req_ready, BARQ}, 3'b010);
  endtask

  task automatic reset_in_data();
    int k;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0777; req_wdata = 16'h0;
    bus_rdata = 16'hDEAD; BAGD = 1'b1; TargetReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!DataStrobe && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("reached_data", DataStrobe, 1);
    Reset = 1'b1;
    @(negedge clk);
    check("rst_bus_released", {BARQ, AddressValid, DataStrobe, rsp_valid}, 0);
    check("rst_state_idle", fsm_state, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_error", Error, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    Reset = 1'b0; BAGD = 1'b0;
    @(negedge clk);
    check("rst_no_rsp", rsp_valid, 0);
    model_rdata = 16'h0;
  endtask

  task automatic back_to_back();
    int accepts, rsp_n, second_at;
    logic [9:0] trace, exp_tr;
    accepts = 0; rsp_n = 0; second_at = -1; trace = '0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0ABC; req_wdata = 16'h1111;
    BAGD = 1'b1; TargetReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (req_valid && req_ready) begin
        accepts++;
        if (accepts == 2) second_at = i;
      end
      @(negedge clk);
      if (accepts == 2) req_valid = 1'b0;
      trace[i] = BARQ;
      if (rsp_valid) begin
        rsp_n++;
        check("b2b_err", Error, 0);
      end
    end
    for (int i = 0; i < 10; i++) exp_tr[i] = ((i % 5) < 3);
    check("b2b_barq_trace", trace, exp_tr);
    check("b2b_accepts", accepts, 2);
    check("b2b_second_accept", second_at, 5);
    check("b2b_rsp_count", rsp_n, 2);
    req_valid = 1'b0; BAGD = 1'b0; TargetReady = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- test ----------------
  vec_t tbl[8];
  vec_t v;

  initial begin
    tbl[0] = '{1'b1, 16'h0012, 16'hA5A5, 16'hFFFF, 0, 0, 0, 8'h00, 16'h0000, 4, 3, 2, 1};
    tbl[1] = '{1'b0, 16'h0040, 16'h0000, 16'h1234, 4, 3, 0, 8'h00, 16'h1234, 11, 10, 5, 4};
    tbl[2] = '{1'b1, 16'h0100, 16'h5A5A, 16'h0000, 9, 0, 0, 8'h01, 16'h1234, 9, 8, 0, 0};
    tbl[3] = '{1'b0, 16'h0200, 16'h0000, 16'h5555, 0, 1, 3, 8'h03, 16'h1234, 5, 4, 3, 2};
    tbl[4] = '{1'b0, 16'h0300, 16'h0000, 16'h7777, 1, 7, 0, 8'h02, 16'h1234, 10, 9, 7, 6};
    tbl[5] = '{1'b0, 16'h0400, 16'h0000, 16'hBEEF, 0, 0, 0, 8'h00, 16'hBEEF, 4, 3, 2, 1};
    tbl[6] = '{1'b1, 16'h0500, 16'hC3C3, 16'h9999, 2, 2, 0, 8'h00, 16'hBEEF, 8, 7, 4, 3};
    tbl[7] = '{1'b1, 16'h0600, 16'h3C3C, 16'h0000, 0, 0, 1, 8'h03, 16'hBEEF, 3, 2, 1, 0};

    Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    BAGD = 1'b0; TargetReady = 1'b0; bus_rdata = '0;
    model_rdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {BARQ, AddressValid, DataStrobe, bus_we, rsp_valid, Error}, 0);
    check("reset_bus", {bus_addr, bus_wdata, rsp_rdata}, 0);
    check("reset_ready_state", {req_ready, fsm_state}, 4'b1000);
    Reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i]);
      model_rdata = tbl[i].e_rdata;
    end

    reset_in_data();
    back_to_back();

    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = 16'($urandom);
      v.wdata = 16'($urandom);
      v.rdata = 16'($urandom);
      v.g     = int'($urandom_range(0, 9));
      v.w     = int'($urandom_range(0, 7));
      v.drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      v = model(v, model_rdata);
      run_txn(v);
      model_rdata = v.e_rdata;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
